tick_scheduler: RTL
===================

Name: tick_scheduler

Overview:
- Multi-channel clock-enable scheduler built around a shared pixel-clock prescaler.
- The prescaler divides Pixelclock by PRESCALE into a base tick. Up to N_CH channels then sub-divide the base tick by run-time programmable ratios.
- Game and display logic, such as sprite motion, animation and timers, get single-cycle enable pulses without each owning a divider chain.
- A start/stop FSM sequences the shared prescaler. A valid/ready config port reprograms channels glitch-free at base-tick boundaries.

Parameters:
- PRESCALE, 6250, Pixelclock cycles per base tick (>=2).
- N_CH, 4, number of tick channels (2..8).
- DIV_W, 16, width of per-channel divide ratio.

Ports:
- Pixelclock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- start  in  1  request RUN (sampled while IDLE).
- stop  in  1  request IDLE (sampled while RUN; stop wins over start).
- cfg_valid  in  1  config request.
- cfg_ready  out  1  config slot free.
- cfg_ch  in  clog2(N_CH)  target channel.
- cfg_div  in  DIV_W  divide ratio in base ticks; 0 means channel silent.
- cfg_en  in  1  channel enable.
- base_tick  out  1  one-cycle pulse every PRESCALE cycles in RUN.
- tick  out  N_CH  per-channel one-cycle pulses.
- busy  out  1  high in RUN.

Behaviour:
- Reset values:
  - state IDLE; prescaler 0; all channel counters 0.
  - active div 0 and active en 0 for every channel; pending flag 0.
  - base_tick 0, tick 0, busy 0, cfg_ready 1.
- FSM IDLE <-> RUN:
  - IDLE -> RUN on an edge with start=1 and stop=0; prescaler loads 0.
  - RUN -> IDLE on an edge with stop=1.
  - On entering IDLE: prescaler and all channel counters clear to 0, and a pending config is applied on that same edge.
- Prescaler:
  - In RUN, increments on every edge.
  - On the edge where it equals PRESCALE-1, it wraps to 0 and the registered base_tick is set for exactly one cycle.
  - First base_tick is visible PRESCALE cycles after the start edge, then every PRESCALE cycles.
  - In IDLE, base_tick and tick are held 0.
- Channel i:
  - Counter advances only on base-tick edges, and only when en=1 and div!=0.
  - If counter==div-1, it wraps to 0 and tick[i] is registered high in the same cycle as base_tick. Otherwise it increments.
  - div=1 gives tick[i] coincident with every base_tick.
  - en=0 or div=0: counter holds 0, tick[i]=0.
- Config handshake:
  - cfg_ready = !pending (combinational); a transfer occurs on an edge with cfg_valid&cfg_ready.
  - In IDLE: div and en are written to channel cfg_ch on that edge and its counter clears.
  - In RUN: the request is latched as pending and cfg_ready drops. It is applied on the next base-tick edge: active div/en written, counter cleared.
  - On the apply edge, tick for that channel is computed from the old settings.
  - cfg_ready returns high the cycle after apply.
  - cfg_* is ignored while cfg_ready=0.
- Simultaneous events:
  - stop on a base-tick edge: no base_tick or tick is generated, and pending is applied.
  - start and transfer on the same IDLE edge: config is applied immediately and RUN begins.
- Reset mid-operation: all state returns to reset values asynchronously; pulses in flight are dropped.

Optional Feature:
- Macro: TICK_SCHED_ONESHOT_EN.
- Defined:
  - Adds input cfg_oneshot (1 bit), latched with each config transfer.
  - A one-shot channel emits a single tick, clears its own active en on that same edge, and emits nothing further until reconfigured.
  - Adds output oneshot_done (N_CH bits): bit i set on that edge, cleared by a new transfer to channel i or by reset.
- Undefined: ports absent; all channels periodic.

Test Plan:
- PRESCALE=4, reset, start pulse -> base_tick high 4 cycles after start edge, then every 4 cycles; busy=1; tick=0 with no config.
- IDLE config ch0 div=3 en=1, ch1 div=1 en=1, then start -> tick[1] on every base_tick; tick[0] on the 3rd, 6th, 9th base_tick.
- RUN, ch0 div=3, write div=2 mid-period -> cfg_ready low until next base_tick; a second cfg_valid is ignored; new period of 2 counts from the apply edge.
- cfg_div=0 en=1 on ch2 -> tick[2] never asserts over 20 base ticks.
- stop coincident with base-tick edge, with a pending config -> no base_tick that cycle; busy=0; config visible after restart; cfg_ready=1.
- Assert reset during RUN with pending config -> all outputs 0 and cfg_ready=1 immediately; after start, no channel ticks until reconfigured.

Source files
------------

// File: rtl/tick_scheduler.sv
// Multi-channel clock-enable scheduler: shared Pixelclock prescaler feeding N_CH programmable tick dividers (optional one-shot mode: TICK_SCHED_ONESHOT_EN).
// Latency: base_tick registered, first pulse PRESCALE cycles after the start edge; tick[i] coincident with base_tick.
// Backpressure: cfg_ready drops while a RUN-time config waits for the next base-tick edge; cfg_* ignored meanwhile.
module tick_scheduler #(
    parameter int PRESCALE = 6250,
    parameter int N_CH     = 4,
    parameter int DIV_W    = 16
) (
    input  logic                    Pixelclock,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    stop,
    input  logic                    cfg_valid,
    output logic                    cfg_ready,
    input  logic [$clog2(N_CH)-1:0] cfg_ch,
    input  logic [DIV_W-1:0]        cfg_div,
    input  logic                    cfg_en,
    output logic                    base_tick,
    output logic [N_CH-1:0]         tick,
    output logic                    busy
`ifdef TICK_SCHED_ONESHOT_EN
    ,
    input  logic                    cfg_oneshot,
    output logic [N_CH-1:0]         oneshot_done
`endif
);

    localparam int CH_W = $clog2(N_CH);
    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic [PS_W-1:0]  presc_q;
    logic             base_tick_q;
    logic [N_CH-1:0]  tick_q;

    logic [DIV_W-1:0] div_q [N_CH];
    logic [DIV_W-1:0] cnt_q [N_CH];
    logic [N_CH-1:0]  en_q;

    logic             pend_q;
    logic [CH_W-1:0]  pend_ch;
    logic [DIV_W-1:0] pend_div;
    logic             pend_en;

    logic             xfer;
    logic             bt_edge;
    logic             stop_edge;
    logic             apply_pend;
    logic             direct_wr;
    logic             cfg_wr;
    logic [CH_W-1:0]  wr_ch;
    logic [DIV_W-1:0] wr_div;
    logic             wr_en;

`ifdef TICK_SCHED_ONESHOT_EN
    logic [N_CH-1:0]  os_q;
    logic [N_CH-1:0]  done_q;
    logic             pend_os;
    logic             wr_os;
`endif

    // A transfer happens whenever no config is waiting; in RUN it is parked until the next base-tick edge.
    assign cfg_ready  = !pend_q;
    assign xfer       = cfg_valid && !pend_q;
    assign stop_edge  = (state_q == RUN) && stop;
    assign bt_edge    = (state_q == RUN) && !stop && (presc_q == PS_LAST);
    assign apply_pend = pend_q && (bt_edge || stop_edge);
    // In IDLE (and on the edge that drops back to IDLE) there is no tick phase to protect, so write straight through.
    assign direct_wr  = xfer && ((state_q == IDLE) || stop_edge);
    assign cfg_wr     = apply_pend || direct_wr;
    assign wr_ch      = apply_pend ? pend_ch  : cfg_ch;
    assign wr_div     = apply_pend ? pend_div : cfg_div;
    assign wr_en      = apply_pend ? pend_en  : cfg_en;
`ifdef TICK_SCHED_ONESHOT_EN
    assign wr_os        = apply_pend ? pend_os : cfg_oneshot;
    assign oneshot_done = done_q;
`endif

    assign base_tick = base_tick_q;
    assign tick      = tick_q;
    assign busy      = (state_q == RUN);

    // Run-state register.
    always_ff @(posedge Pixelclock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: stop always wins; start only honoured without stop.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start && !stop) state_d = RUN;
            RUN:     if (stop)           state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Shared prescaler; base_tick is suppressed on a stop edge because bt_edge excludes it.
    always_ff @(posedge Pixelclock or posedge reset) begin
        if (reset) begin
            presc_q     <= '0;
            base_tick_q <= 1'b0;
        end else begin
            base_tick_q <= 1'b0;
            if (state_q != RUN || stop) begin
                presc_q <= '0;
            end else if (presc_q == PS_LAST) begin
                presc_q     <= '0;
                base_tick_q <= 1'b1;
            end else begin
                presc_q <= presc_q + PS_W'(1);
            end
        end
    end

    // Parked RUN-time config; released on the edge it gets applied.
    always_ff @(posedge Pixelclock or posedge reset) begin
        if (reset) begin
            pend_q   <= 1'b0;
            pend_ch  <= '0;
            pend_div <= '0;
            pend_en  <= 1'b0;
`ifdef TICK_SCHED_ONESHOT_EN
            pend_os  <= 1'b0;
`endif
        end else if (apply_pend) begin
            pend_q <= 1'b0;
        end else if (xfer && (state_q == RUN) && !stop) begin
            pend_q   <= 1'b1;
            pend_ch  <= cfg_ch;
            pend_div <= cfg_div;
            pend_en  <= cfg_en;
`ifdef TICK_SCHED_ONESHOT_EN
            pend_os  <= cfg_oneshot;
`endif
        end
    end

    // Channel dividers; the tick on an apply edge uses the old settings, then the new ones overwrite.
    always_ff @(posedge Pixelclock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_CH; i++) begin
                div_q[i] <= '0;
                cnt_q[i] <= '0;
            end
            en_q   <= '0;
            tick_q <= '0;
`ifdef TICK_SCHED_ONESHOT_EN
            os_q   <= '0;
            done_q <= '0;
`endif
        end else begin
            tick_q <= '0;
            for (int i = 0; i < N_CH; i++) begin
`ifdef TICK_SCHED_ONESHOT_EN
                if (xfer && (cfg_ch == CH_W'(i))) begin
                    done_q[i] <= 1'b0;
                end
`endif
                if (stop_edge) begin
                    cnt_q[i] <= '0;
                end else if (bt_edge && en_q[i] && (div_q[i] != '0)) begin
                    if (cnt_q[i] == div_q[i] - DIV_W'(1)) begin
                        cnt_q[i]  <= '0;
                        tick_q[i] <= 1'b1;
`ifdef TICK_SCHED_ONESHOT_EN
                        if (os_q[i]) begin
                            en_q[i]   <= 1'b0;
                            done_q[i] <= 1'b1;
                        end
`endif
                    end else begin
                        cnt_q[i] <= cnt_q[i] + DIV_W'(1);
                    end
                end
                if (cfg_wr && (wr_ch == CH_W'(i))) begin
                    div_q[i] <= wr_div;
                    en_q[i]  <= wr_en;
                    cnt_q[i] <= '0;
`ifdef TICK_SCHED_ONESHOT_EN
                    os_q[i]  <= wr_os;
`endif
                end
            end
        end
    end

endmodule
